fifo_ext: RTL

Parametrised synchronous FIFO, the next generation of the team's `fifo` buffer. It adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a compile-time first-word-fall-through read mode.

It sits between a producer and a consumer in the same clock domain, such as UART RX/TX paths or SPI sample buffering.

---
 rtl/fifo_ext.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_ext.sv
// fifo_ext: parametrised synchronous FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (r_data shows the head word combinationally whenever !empty). With the macro
// undefined, r_data is registered and updated only by an accepted read.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   wr, w_data   write request and data
//   rd           read request (pop in FWFT mode)
//   r_data       read data
//   err_clr      synchronous clear of overflow / underflow (a same-cycle set wins)
//   empty, full, almost_empty, almost_full, count   status from registered pointers
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module fifo_ext #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned A_WIDTH   = 3,
  parameter int unsigned AF_THRESH = 2**A_WIDTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               rd,
  output logic [D_WIDTH-1:0] r_data,
  input  logic               err_clr,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic [A_WIDTH:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned Depth = 2**A_WIDTH;

  typedef logic [A_WIDTH:0] ptr_t;

  localparam ptr_t DepthCnt = ptr_t'(Depth);
  localparam ptr_t AfCnt    = ptr_t'(AF_THRESH);
  localparam ptr_t AeCnt    = ptr_t'(AE_THRESH);

  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= Depth))) begin : g_bad_params
    $fatal(1, "fifo_ext: thresholds must satisfy AE_THRESH < AF_THRESH <= 2**A_WIDTH");
  end

  logic [D_WIDTH-1:0] mem_q [Depth];
  ptr_t               wptr_q, rptr_q;
  logic               overflow_q, underflow_q;
  logic               rd_acc, wr_acc;
  logic               ov_set, un_set;

  // Extra MSB on each pointer distinguishes full from empty; count wraps naturally.
  assign count = wptr_q - rptr_q;

  always_comb begin
    empty        = (count == '0);
    full         = (count == DepthCnt);
    almost_empty = (count <= AeCnt);
    almost_full  = (count >= AfCnt);
  end

  // A write into a full FIFO is allowed only when a read frees the slot this cycle.
  always_comb begin
    rd_acc = rd && !empty;
    wr_acc = wr && (!full || rd_acc);
    ov_set = wr && !wr_acc;
    un_set = rd && !rd_acc;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q[A_WIDTH-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + ptr_t'(1);
      if (rd_acc) rptr_q <= rptr_q + ptr_t'(1);
      overflow_q  <= ov_set | (overflow_q  & ~err_clr);
      underflow_q <= un_set | (underflow_q & ~err_clr);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_FWFT_EN
  // Head word is always visible; rd only advances the read pointer.
  assign r_data = mem_q[rptr_q[A_WIDTH-1:0]];
`else
  logic [D_WIDTH-1:0] r_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
    end else if (rd_acc) begin
      r_data_q <= mem_q[rptr_q[A_WIDTH-1:0]];
    end
  end

  assign r_data = r_data_q;
`endif

endmodule
